// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller: tracks SD frame boundaries from header_finder
// pulses, declares lock after LOCK_COUNT verified boundaries and resets the parser on loss.
module frame_sync_ctrl #(
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned CHECK_BYTES   = 8,
  parameter int unsigned CHECK_TIMEOUT = 16,
  parameter int unsigned MIN_FRAME     = 21,
  parameter int unsigned MAX_FRAME     = 1441
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  output logic        axiir,
  output logic [7:0]  axiid_out,
  output logic        axiiv_out,
  input  logic        valid_header,
  input  logic [10:0] frame_size,
  input  logic        fifo_full,
  output logic        parser_rst,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_lost,
  output logic [15:0] frame_count
);

  localparam int unsigned MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LC_L  = MW'(LOCK_COUNT);
  localparam logic [10:0]   CB_L  = 11'(CHECK_BYTES);
  localparam logic [4:0]    CT_L  = 5'(CHECK_TIMEOUT);
  localparam logic [10:0]   MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0]   MAX_L = 11'(MAX_FRAME);

  typedef enum logic [1:0] {SEARCH, FRAME, CHECK} state_t;

  state_t          state;
  logic [10:0]     byte_cnt;
  logic [10:0]     frame_len;
  logic [4:0]      chk_cyc;
  logic [MW-1:0]   match_cnt;

  logic            accept;
  logic            hdr_seen;
  logic            legal;
  logic            window_expired;
  logic            start;
  logic            lose;
  logic [10:0]     start_cnt;
  logic [MW-1:0]   match_inc;

  // Byte path: pass-through data, handshake gated by backpressure and parser reset
  assign axiir     = !fifo_full && !parser_rst;
  assign axiid_out = axiid;
  assign axiiv_out = axiiv && axiir;
  assign accept    = axiiv_out;

  // Headers arriving while the parser is being reset are stale and ignored
  assign hdr_seen       = valid_header && !parser_rst;
  assign legal          = hdr_seen && (frame_size >= MIN_L) && (frame_size <= MAX_L);
  assign window_expired = (byte_cnt >= CB_L) || (chk_cyc >= CT_L);
  assign start_cnt      = accept ? 11'd5 : 11'd4;
  assign match_inc      = (match_cnt == LC_L) ? match_cnt : match_cnt + MW'(1);

  assign start = !fifo_full && legal && (state == SEARCH || state == CHECK);
  assign lose  = !fifo_full &&
                 ((state == FRAME && hdr_seen) ||
                  (state == CHECK && !legal && window_expired));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      byte_cnt    <= '0;
      frame_len   <= '0;
      chk_cyc     <= '0;
      match_cnt   <= '0;
      parser_rst  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_lost   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      sync_lost   <= 1'b0;
      parser_rst  <= 1'b0;
      locked      <= lose ? 1'b0 : (match_cnt == LC_L);
      if (lose) begin
        state      <= SEARCH;
        byte_cnt   <= '0;
        chk_cyc    <= '0;
        match_cnt  <= '0;
        sync_lost  <= 1'b1;
        parser_rst <= 1'b1;
      end else if (start) begin
        // The 4 header bytes are already behind us when header_finder pulses
        state       <= FRAME;
        frame_len   <= frame_size;
        byte_cnt    <= start_cnt;
        match_cnt   <= (state == CHECK) ? match_inc : '0;
        frame_start <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (!fifo_full) begin
        case (state)
          FRAME: begin
            if (accept) begin
              if (byte_cnt + 11'd1 == frame_len) begin
                state    <= CHECK;
                byte_cnt <= '0;
                chk_cyc  <= '0;
              end else begin
                byte_cnt <= byte_cnt + 11'd1;
              end
            end
          end
          CHECK: begin
            // Timeout clock only runs once the next header's bytes have arrived
            if (byte_cnt >= 11'd4 && chk_cyc != 5'd31) chk_cyc <= chk_cyc + 5'd1;
            if (accept) byte_cnt <= byte_cnt + 11'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: a frame-position model predicts every output
// each cycle, and literal checks pin the headline scenarios.
module tb_frame_sync_ctrl;

  localparam int LOCK = 3;
  localparam int CB   = 8;
  localparam int CT   = 16;
  localparam int MINF = 21;
  localparam int MAXF = 1441;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  axiid;
  logic        axiiv;
  logic        axiir;
  logic [7:0]  axiid_out;
  logic        axiiv_out;
  logic        valid_header;
  logic [10:0] frame_size;
  logic        fifo_full;
  logic        parser_rst;
  logic        frame_start;
  logic        locked;
  logic        sync_lost;
  logic [15:0] frame_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int sl_cnt = 0;
  int pr_cnt = 0;

  frame_sync_ctrl #(
    .LOCK_COUNT(LOCK), .CHECK_BYTES(CB), .CHECK_TIMEOUT(CT),
    .MIN_FRAME(MINF), .MAX_FRAME(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv), .axiir(axiir),
    .axiid_out(axiid_out), .axiiv_out(axiiv_out), .valid_header(valid_header),
    .frame_size(frame_size), .fifo_full(fifo_full), .parser_rst(parser_rst),
    .frame_start(frame_start), .locked(locked), .sync_lost(sync_lost),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: m_rem = bytes still owed to the current frame; once it hits 0 we sit in
  // the boundary window counting bytes (m_wb) and cycles (m_wc) until a header.
  bit          m_sync, m_fs, m_sl, m_pr, m_lk;
  int          m_rem, m_wb, m_wc, m_streak;
  logic [15:0] m_cnt;

  task automatic m_begin(input int streak, input bit acc);
    m_sync   = 1'b1;
    m_rem    = int'(frame_size) - (acc ? 5 : 4);
    m_streak = streak;
    m_fs     = 1'b1;
    m_cnt    = m_cnt + 16'd1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync = 0; m_rem = 0; m_wb = 0; m_wc = 0; m_streak = 0;
      m_cnt = 16'd0; m_fs = 0; m_sl = 0; m_pr = 0; m_lk = 0;
    end else begin
      bit hv, acc, legal, loss, lk_next;
      hv      = valid_header && !m_pr;
      acc     = axiiv && !fifo_full && !m_pr;
      legal   = hv && int'(frame_size) >= MINF && int'(frame_size) <= MAXF;
      lk_next = (m_streak == LOCK);
      loss    = 1'b0;
      m_fs = 0; m_sl = 0; m_pr = 0;
      if (!fifo_full) begin
        if (!m_sync) begin
          if (legal) m_begin(0, acc);
        end else if (m_rem > 0) begin
          if (hv) loss = 1'b1;
          else if (acc) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_wb = 0; m_wc = 0; end
          end
        end else begin
          if (legal) m_begin((m_streak + 1 > LOCK) ? LOCK : m_streak + 1, acc);
          else if (m_wb >= CB || m_wc >= CT) loss = 1'b1;
          else begin
            if (m_wb >= 4 && m_wc < 31) m_wc = m_wc + 1;
            if (acc) m_wb = m_wb + 1;
          end
        end
      end
      if (loss) begin
        m_sync = 0; m_streak = 0; m_sl = 1; m_pr = 1;
      end
      m_lk = loss ? 1'b0 : lk_next;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("axiir",       16'(axiir),       16'(!fifo_full && !m_pr));
    chk("axiiv_out",   16'(axiiv_out),   16'(axiiv && !fifo_full && !m_pr));
    chk("axiid_out",   16'(axiid_out),   16'(axiid));
    chk("frame_start", 16'(frame_start), 16'(m_fs));
    chk("sync_lost",   16'(sync_lost),   16'(m_sl));
    chk("parser_rst",  16'(parser_rst),  16'(m_pr));
    chk("locked",      16'(locked),      16'(m_lk));
    chk("frame_count", frame_count,      m_cnt);
    fs_cnt = fs_cnt + int'(frame_start);
    sl_cnt = sl_cnt + int'(sync_lost);
    pr_cnt = pr_cnt + int'(parser_rst);
  end

  task automatic drive(input logic v, input logic h, input logic [10:0] sz, input logic full);
    axiiv = v; valid_header = h; frame_size = sz; fifo_full = full;
    axiid = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_bytes(input int n);
    repeat (n) drive(1'b1, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic hdr(input logic [10:0] sz);
    drive(1'b0, 1'b1, sz, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; axiiv = 0; valid_header = 0; frame_size = 0; fifo_full = 0; axiid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_axiir", 16'(axiir), 16'd1);
    rst = 1'b0;

    // Illegal headers in SEARCH are ignored
    hdr(11'd10);
    hdr(11'd1442);
    idle(2);
    chk("illegal_hdr_count", frame_count, 16'd0);

    // Two back-to-back 418-byte frames
    hdr(11'd418);
    send_bytes(414);
    hdr(11'd418);
    chk("two_frames_count", frame_count, 16'd2);
    chk("two_frames_locked", 16'(locked), 16'd0);

    // Frames 3 and 4: lock one cycle after the 4th frame_start
    send_bytes(414);
    hdr(11'd418);
    send_bytes(414);
    hdr(11'd418);
    chk("lock_not_yet", 16'(locked), 16'd0);
    send_bytes(1);
    chk("lock_set", 16'(locked), 16'd1);
    send_bytes(99);

    // Backpressure mid-frame freezes counting
    repeat (10) drive(1'b1, 1'b0, 11'd0, 1'b1);
    send_bytes(314);
    hdr(11'd418);
    chk("full_no_loss", 16'(sl_cnt), 16'd0);
    chk("full_count", frame_count, 16'd5);
    chk("full_locked", 16'(locked), 16'd1);

    // Missing header after a boundary: byte limit
    send_bytes(414);
    send_bytes(12);
    chk("miss_sl_pulses", 16'(sl_cnt), 16'd1);
    chk("miss_pr_pulses", 16'(pr_cnt), 16'd1);
    chk("miss_locked", 16'(locked), 16'd0);
    chk("miss_count", frame_count, 16'd5);

    // Missing header: cycle timeout with only the header bytes present
    hdr(11'd21);
    send_bytes(17);
    send_bytes(4);
    idle(20);
    chk("timeout_sl", 16'(sl_cnt), 16'd2);
    chk("timeout_count", frame_count, 16'd6);

    // MAX boundary accepted, then an illegal header mid-frame still kills sync
    hdr(11'd1442);
    hdr(11'd1441);
    send_bytes(5);
    hdr(11'd10);
    idle(3);
    chk("early_illegal_sl", 16'(sl_cnt), 16'd3);
    chk("max_count", frame_count, 16'd7);

    // Early legal header at byte 100 of a 418-byte frame
    hdr(11'd418);
    send_bytes(96);
    hdr(11'd418);
    idle(3);
    chk("early_hdr_sl", 16'(sl_cnt), 16'd4);
    chk("early_hdr_count", frame_count, 16'd8);

    // Header with a same-cycle byte, then a header coinciding with the byte limit
    drive(1'b1, 1'b1, 11'd21, 1'b0);
    send_bytes(16);
    send_bytes(8);
    hdr(11'd21);
    idle(2);
    chk("prio_sl", 16'(sl_cnt), 16'd4);
    chk("prio_count", frame_count, 16'd10);
    chk("fs_pulses", 16'(fs_cnt), 16'd10);
    chk("pr_pulses", 16'(pr_cnt), 16'd4);

    // Asynchronous reset mid-frame
    send_bytes(10);
    rst = 1'b1;
    #1;
    chk("midrst_count", frame_count, 16'd0);
    chk("midrst_locked", 16'(locked), 16'd0);
    chk("midrst_axiir", 16'(axiir), 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    hdr(11'd418);
    chk("post_rst_count", frame_count, 16'd1);
    send_bytes(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sync_ctrl.md
FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3: verified consecutive frame boundaries needed to assert locked.
REQ-002 SHALL have parameter CHECK_BYTES, default 8: accepted bytes allowed after a frame boundary before a missing header is declared.
REQ-003 SHALL have parameter CHECK_TIMEOUT, default 16: clock cycles allowed after a frame boundary before a missing header is declared.
REQ-004 SHALL have parameters MIN_FRAME and MAX_FRAME, defaults 21 and 1441: legal frame_size range in bytes, inclusive.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 axiid  in  8  byte from the SD byte source.
REQ-008 axiiv  in  1  axiid valid.
REQ-009 axiir  out  1  ready to the byte source; a byte is accepted when axiiv && axiir.
REQ-010 axiid_out  out  8  axiid passed through combinationally to header_finder/plexer.
REQ-011 axiiv_out  out  1  axiiv && axiir, to header_finder/plexer.
REQ-012 valid_header  in  1  one-cycle pulse from header_finder.
REQ-013 frame_size  in  11  total frame length in bytes, header included; sampled when valid_header=1.
REQ-014 fifo_full  in  1  plexer main-data FIFO backpressure.
REQ-015 parser_rst  out  1  one-cycle synchronous reset pulse to header_finder and plexer.
REQ-016 frame_start  out  1  one-cycle pulse per accepted header.
REQ-017 locked  out  1  stream in sync.
REQ-018 sync_lost  out  1  one-cycle pulse on loss of sync.
REQ-019 frame_count  out  16  accepted headers since reset; wraps 0xFFFF->0.

Function
REQ-020 axiir SHALL equal !fifo_full && !parser_rst; no byte is accepted in a parser_rst cycle.
REQ-021 States SHALL be SEARCH, FRAME, CHECK; registers byte_cnt[10:0], frame_len[10:0], chk_cyc[4:0], match_cnt (saturating at LOCK_COUNT).
REQ-022 A header SHALL be legal iff valid_header=1 and MIN_FRAME <= frame_size <= MAX_FRAME; illegal headers SHALL be ignored in SEARCH and treated as no header elsewhere.
REQ-023 SEARCH + legal header -> FRAME; frame_len<=frame_size; byte_cnt<=4, or 5 if a byte is accepted that same cycle; match_cnt<=0; frame_start=1; frame_count+1.
REQ-024 FRAME: byte_cnt +1 per accepted byte; on the accept that makes byte_cnt==frame_len -> CHECK, byte_cnt<=0, chk_cyc<=0.
REQ-025 FRAME + any valid_header -> sync loss (early header).
REQ-026 CHECK: byte_cnt +1 per accepted byte; chk_cyc +1 per cycle while byte_cnt>=4, saturating; frozen while fifo_full=1.
REQ-027 CHECK + legal header -> FRAME as in REQ-023, except match_cnt SHALL increment (saturating) instead of clear.
REQ-028 CHECK with byte_cnt reaching CHECK_BYTES or chk_cyc reaching CHECK_TIMEOUT and no legal header -> sync loss.
REQ-029 Sync loss SHALL in the next cycle: pulse sync_lost and parser_rst for exactly one cycle, clear match_cnt and byte_cnt, enter SEARCH; frame_count SHALL be unchanged.
REQ-030 locked SHALL be registered: 1 iff match_cnt==LOCK_COUNT; cleared in the sync_lost cycle.
REQ-031 A legal header coinciding with a timeout condition SHALL take priority (frame accepted).
REQ-032 fifo_full SHALL freeze byte_cnt and chk_cyc; state and outputs hold.

Reset
REQ-033 rst=1 SHALL immediately, in any state including mid-frame: state=SEARCH, all counters 0, frame_len=0, locked=0, frame_start=0, sync_lost=0, parser_rst=0, frame_count=0.
REQ-034 After rst deasserts, the first rising edge SHALL act on SEARCH rules.

Verification
REQ-035 Reset: rst=1 mid-FRAME -> SEARCH, locked=0, frame_count=0, axiir=1 with fifo_full=0.
REQ-036 Header with frame_size=418, then 414 bytes, then a header -> frame_start x2, frame_count=2, state FRAME, locked=0.
REQ-037 Four consecutive 418-byte frames with headers on boundaries -> locked=1 from the cycle after the 4th frame_start.
REQ-038 Locked stream, 8 bytes after a boundary with no valid_header -> one sync_lost pulse, one parser_rst pulse, axiir=0 that cycle, locked=0, SEARCH.
REQ-039 fifo_full=1 for 10 cycles mid-FRAME with axiiv=1 -> axiir=0, axiiv_out=0, byte_cnt unchanged, no sync loss.
REQ-040 valid_header with frame_size=10 in SEARCH -> no frame_start, state SEARCH; valid_header at byte_cnt=100 of a 418-byte frame -> sync_lost.
